// File: rtl/collide_arbiter_pkg.sv
// Grid and arbiter parameters shared by the collision-check arbiter slice.
// Holds the grid geometry, requester count, checker latency and FSM state type.
package collide_arbiter_pkg;

  localparam int X_bits       = 8;
  localparam int Y_bits       = 7;
  localparam int PIXELS_X     = 160;
  localparam int PIXELS_Y     = 120;

  localparam int REQ_num      = 4;
  localparam int REQ_num_bits = 2;
  localparam int CHECK_LAT    = 2;

  // Wide enough to hold CHECK_LAT-1; never narrower than one bit.
  localparam int LAT_bits     = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    RESPOND = 2'd2
  } arb_state_e;

  function automatic logic [REQ_num-1:0] idx_to_onehot(input logic [REQ_num_bits-1:0] idx);
    return {{(REQ_num-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/collide_arbiter_if.sv
// Requester and checker bus of the collision arbiter.
// Handshake: a requester holds req and req_x/req_y until it sees its grant bit (one-cycle pulse); its done bit pulses once later with result valid in that cycle only.
interface collide_arbiter_if;
  import collide_arbiter_pkg::*;

  logic [REQ_num-1:0]             req;
  logic [REQ_num-1:0][X_bits-1:0] req_x;
  logic [REQ_num-1:0][Y_bits-1:0] req_y;
  logic [REQ_num-1:0]             grant;
  logic [REQ_num-1:0]             done;
  logic                           result;
  logic                           busy;
  logic [X_bits-1:0]              collide_x;
  logic [Y_bits-1:0]              collide_y;
  logic                           collision;
  logic [REQ_num_bits-1:0]        owner_o;
  arb_state_e                     state_o;

  modport slave (
    input  req, req_x, req_y, collision,
    output grant, done, result, busy, collide_x, collide_y, owner_o, state_o
  );

  modport master (
    output req, req_x, req_y, collision,
    input  grant, done, result, busy, collide_x, collide_y, owner_o, state_o
  );

endinterface

// File: rtl/collide_arbiter_rr_picker.sv
// Combinational winner selection: requester 0 wins outright in setup mode,
// otherwise the first requesting index found scanning upward from rr_ptr.
module collide_arbiter_rr_picker
  import collide_arbiter_pkg::*;
(
  input  logic [REQ_num-1:0]      req,
  input  logic [REQ_num_bits-1:0] rr_ptr,
  input  logic                    SETUP_MODE,
  output logic                    any,
  output logic [REQ_num_bits-1:0] w
);

  assign any = |req;

  always_comb begin
    logic [REQ_num_bits:0] slot;
    logic                  found;
    w     = '0;
    found = 1'b0;
    slot  = '0;
    if (SETUP_MODE && req[0]) begin
      found = 1'b1;
    end
    for (int i = 0; i < REQ_num; i++) begin
      // Modulo done by one conditional subtract so REQ_num need not be a power of two.
      slot = {1'b0, rr_ptr} + (REQ_num_bits+1)'(i);
      if (slot >= (REQ_num_bits+1)'(REQ_num)) begin
        slot = slot - (REQ_num_bits+1)'(REQ_num);
      end
      if (!found && req[slot[REQ_num_bits-1:0]]) begin
        w     = slot[REQ_num_bits-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collide_arbiter.sv
// Shares one fixed-latency collision checker among REQ_num requesters,
// one check in flight at a time, round-robin with a setup-mode override for requester 0.
module collide_arbiter
  import collide_arbiter_pkg::*;
(
  input  logic               Clk,
  input  logic               RESET_SIM,
  input  logic               SETUP_MODE,
  collide_arbiter_if.slave   bus
);

  arb_state_e              state_q, state_d;
  logic [LAT_bits-1:0]     lat_q, lat_d;
  logic [REQ_num_bits-1:0] owner_q, owner_d;
  logic [REQ_num_bits-1:0] rr_q, rr_d;
  logic [REQ_num-1:0]      grant_q, grant_d;
  logic [REQ_num-1:0]      done_q, done_d;
  logic                    result_q, result_d;
  logic [X_bits-1:0]       cx_q, cx_d;
  logic [Y_bits-1:0]       cy_q, cy_d;

  logic                    pick_any;
  logic [REQ_num_bits-1:0] pick_w;

  collide_arbiter_rr_picker u_picker (
    .req        (bus.req),
    .rr_ptr     (rr_q),
    .SETUP_MODE (SETUP_MODE),
    .any        (pick_any),
    .w          (pick_w)
  );

  always_ff @(posedge Clk or posedge RESET_SIM) begin
    if (RESET_SIM) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      owner_q  <= '0;
      rr_q     <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
    end
  end

  // grant/done/result are pulses: they default to zero and are only set on the transition edge.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    grant_d  = '0;
    done_d   = '0;
    result_d = 1'b0;
    cx_d     = cx_q;
    cy_d     = cy_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          cx_d    = bus.req_x[pick_w];
          cy_d    = bus.req_y[pick_w];
          owner_d = pick_w;
          grant_d = idx_to_onehot(pick_w);
          lat_d   = LAT_bits'(CHECK_LAT - 1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LAT_bits'(1);
        end else begin
          result_d = bus.collision;
          done_d   = idx_to_onehot(owner_q);
          state_d  = RESPOND;
        end
      end
      RESPOND: begin
        rr_d    = (owner_q == REQ_num_bits'(REQ_num - 1)) ? '0 : owner_q + REQ_num_bits'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.collide_x = cx_q;
  assign bus.collide_y = cy_q;
  assign bus.owner_o   = owner_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_collide_arbiter.sv
// Directed bench for collide_arbiter: reset, single check, round-robin order,
// setup priority, reset during a check, and withdrawal with pointer wrap.
module tb_collide_arbiter;
  import collide_arbiter_pkg::*;

  logic Clk;
  logic RESET_SIM;
  logic SETUP_MODE;

  collide_arbiter_if bus ();

  collide_arbiter dut (
    .Clk        (Clk),
    .RESET_SIM  (RESET_SIM),
    .SETUP_MODE (SETUP_MODE),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [REQ_num_bits-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Checker model: result of (x,y) appears on collision one edge after the coordinates change,
  // so the arbiter sampling CHECK_LAT=2 edges after the change sees the new answer.
  always @(posedge Clk or posedge RESET_SIM) begin
    if (RESET_SIM) bus.collision <= 1'b0;
    else           bus.collision <= bus.collide_x[0] ^ bus.collide_y[0];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    RESET_SIM  = 1'b1;
    SETUP_MODE = 1'b0;
    bus.req    = '0;
    bus.req_x  = '0;
    bus.req_y  = '0;
    repeat (2) @(posedge Clk);
    #1;
    RESET_SIM  = 1'b0;
  endtask

  // Returns when a grant bit is visible or after a bounded number of cycles.
  task automatic wait_grant();
    for (int i = 0; i < 12; i++) begin
      if (bus.grant != '0) return;
      step();
    end
  endtask

  function automatic logic [REQ_num-1:0] oh(input int idx);
    logic [REQ_num-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (bus.busy !== 1'b0) begin
        n_err++; $display("FAIL reset_busy cyc%0d: got %b want 0", i, bus.busy);
      end
      n_cmp++;
      if (bus.grant !== 4'b0000) begin
        n_err++; $display("FAIL reset_grant cyc%0d: got %b want 0000", i, bus.grant);
      end
      n_cmp++;
      if (bus.done !== 4'b0000) begin
        n_err++; $display("FAIL reset_done cyc%0d: got %b want 0000", i, bus.done);
      end
      step();
    end
    n_cmp++;
    if (bus.collide_x !== 8'h00) begin
      n_err++; $display("FAIL reset_collide_x: got %h want 00", bus.collide_x);
    end
    n_cmp++;
    if (bus.collide_y !== 7'h00) begin
      n_err++; $display("FAIL reset_collide_y: got %h want 00", bus.collide_y);
    end
    n_cmp++;
    if (bus.result !== 1'b0 || bus.owner_o !== 2'd0) begin
      n_err++; $display("FAIL reset_result_owner: got %b/%0d want 0/0", bus.result, bus.owner_o);
    end
  endtask

  task automatic test_single();
    bus.req      = 4'b0100;
    bus.req_x[2] = 8'h3C;
    bus.req_y[2] = 7'h21;
    step();                                   // arbitration edge
    n_cmp++;
    if (bus.grant !== 4'b0100) begin
      n_err++; $display("FAIL single_grant: got %b want 0100", bus.grant);
    end
    n_cmp++;
    if (bus.collide_x !== 8'h3C || bus.collide_y !== 7'h21) begin
      n_err++; $display("FAIL single_coords: got %h/%h want 3c/21", bus.collide_x, bus.collide_y);
    end
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.owner_o !== 2'd2) begin
      n_err++; $display("FAIL single_busy_owner: got %b/%0d want 1/2", bus.busy, bus.owner_o);
    end
    bus.req      = 4'b0000;
    bus.req_x[2] = 8'hFF;                     // must not disturb the check in flight
    step();
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.done !== 4'b0000 || bus.collide_x !== 8'h3C) begin
      n_err++; $display("FAIL single_mid: got g=%b d=%b x=%h want 0000/0000/3c", bus.grant, bus.done, bus.collide_x);
    end
    step();
    n_cmp++;
    if (bus.done !== 4'b0100 || bus.result !== 1'b1) begin
      n_err++; $display("FAIL single_done: got d=%b r=%b want 0100/1", bus.done, bus.result);
    end
    step();
    n_cmp++;
    if (bus.done !== 4'b0000 || bus.result !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL single_after: got d=%b r=%b busy=%b want 0000/0/0", bus.done, bus.result, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [X_bits-1:0] xs [4] = '{8'h11, 8'h22, 8'h34, 8'h47};
    logic [Y_bits-1:0] ys [4] = '{7'h01, 7'h02, 7'h05, 7'h06};
    logic              res [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [REQ_num_bits-1:0] e;
    int last;
    last = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_x[i] = xs[i];
      bus.req_y[i] = ys[i];
    end
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.grant !== oh(e)) begin
        n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, bus.grant, oh(e));
      end
      if (k > 0) begin
        n_cmp++;
        if (cyc - last != 4) begin
          n_err++; $display("FAIL rr_spacing%0d: got %0d want 4", k, cyc - last);
        end
      end
      last = cyc;
      n_cmp++;
      if (bus.collide_x !== xs[e]) begin
        n_err++; $display("FAIL rr_coord%0d: got %h want %h", k, bus.collide_x, xs[e]);
      end
      step();
      step();
      n_cmp++;
      if (bus.done !== oh(e) || bus.result !== res[k]) begin
        n_err++; $display("FAIL rr_done%0d: got d=%b r=%b want %b/%b", k, bus.done, bus.result, oh(e), res[k]);
      end
    end
    bus.req = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_setup_priority();
    do_reset();
    bus.req = 4'b0010;                        // one check for requester 1 leaves rr_ptr=2
    wait_grant();
    bus.req = 4'b0000;
    repeat (3) step();
    SETUP_MODE   = 1'b1;
    bus.req_x[0] = 8'h01;
    bus.req_y[0] = 7'h00;
    bus.req_x[2] = 8'h02;
    bus.req_y[2] = 7'h00;
    bus.req      = 4'b1110;
    wait_grant();
    n_cmp++;
    if (bus.grant !== 4'b0100) begin
      n_err++; $display("FAIL setup_first: got %b want 0100", bus.grant);
    end
    bus.req = 4'b1111;                        // requester 0 arrives mid-check
    step();
    step();
    n_cmp++;
    if (bus.done !== 4'b0100 || bus.result !== 1'b0) begin
      n_err++; $display("FAIL setup_complete: got d=%b r=%b want 0100/0", bus.done, bus.result);
    end
    wait_grant();
    n_cmp++;
    if (bus.grant !== 4'b0001) begin
      n_err++; $display("FAIL setup_override: got %b want 0001", bus.grant);
    end
    step();
    wait_grant();
    n_cmp++;
    if (bus.grant !== 4'b0001) begin
      n_err++; $display("FAIL setup_starve: got %b want 0001", bus.grant);
    end
    SETUP_MODE = 1'b0;                        // takes effect at the next arbitration only
    step();
    step();
    n_cmp++;
    if (bus.done !== 4'b0001 || bus.result !== 1'b1) begin
      n_err++; $display("FAIL setup_done0: got d=%b r=%b want 0001/1", bus.done, bus.result);
    end
    wait_grant();
    n_cmp++;
    if (bus.grant !== 4'b0010) begin
      n_err++; $display("FAIL setup_release: got %b want 0010", bus.grant);
    end
    bus.req = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    saw_done = 1'b0;
    do_reset();
    bus.req_x[2] = 8'h3C;
    bus.req_y[2] = 7'h21;
    bus.req      = 4'b0100;                   // full check leaves rr_ptr=3
    wait_grant();
    bus.req = 4'b0000;
    repeat (3) step();
    bus.req_x[2] = 8'h55;
    bus.req_y[2] = 7'h2A;
    bus.req      = 4'b0100;
    wait_grant();
    bus.req = 4'b0000;
    step();                                   // second CHECK cycle
    #2;
    RESET_SIM = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
      n_err++; $display("FAIL midreset_busy: got busy=%b g=%b want 0/0000", bus.busy, bus.grant);
    end
    n_cmp++;
    if (bus.collide_x !== 8'h00 || bus.collide_y !== 7'h00 || bus.owner_o !== 2'd0) begin
      n_err++; $display("FAIL midreset_regs: got %h/%h/%0d want 00/00/0", bus.collide_x, bus.collide_y, bus.owner_o);
    end
    step();
    RESET_SIM = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done !== 4'b0000) saw_done = 1'b1;
      step();
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_err++; $display("FAIL midreset_no_done: got %b want 0", saw_done);
    end
    bus.req = 4'b1010;
    wait_grant();
    n_cmp++;
    if (bus.grant !== 4'b0010) begin
      n_err++; $display("FAIL midreset_rrptr: got %b want 0010", bus.grant);
    end
    bus.req = 4'b0000;
    repeat (3) step();
  endtask

  task automatic test_withdraw_wrap();
    logic saw_grant;
    saw_grant = 1'b0;
    do_reset();
    bus.req_x[2] = 8'h3C;
    bus.req_y[2] = 7'h21;
    bus.req      = 4'b0100;
    wait_grant();
    bus.req = 4'b0000;
    step();
    step();
    n_cmp++;
    if (bus.done !== 4'b0100) begin
      n_err++; $display("FAIL wrap_respond: got %b want 0100", bus.done);
    end
    bus.req_x[3] = 8'h7F;
    bus.req_y[3] = 7'h7F;
    bus.req      = 4'b1000;                   // pulse only during RESPOND
    step();
    bus.req = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      if (bus.grant !== 4'b0000) saw_grant = 1'b1;
      step();
    end
    n_cmp++;
    if (saw_grant !== 1'b0) begin
      n_err++; $display("FAIL wrap_withdraw: got %b want 0", saw_grant);
    end
    bus.req_x[0] = 8'h10;
    bus.req_y[0] = 7'h01;
    bus.req      = 4'b1001;
    wait_grant();
    n_cmp++;
    if (bus.grant !== 4'b1000 || bus.collide_x !== 8'h7F) begin
      n_err++; $display("FAIL wrap_first: got g=%b x=%h want 1000/7f", bus.grant, bus.collide_x);
    end
    bus.req = 4'b0001;
    step();
    step();
    n_cmp++;
    if (bus.done !== 4'b1000 || bus.result !== 1'b0) begin
      n_err++; $display("FAIL wrap_done3: got d=%b r=%b want 1000/0", bus.done, bus.result);
    end
    wait_grant();
    n_cmp++;
    if (bus.grant !== 4'b0001) begin
      n_err++; $display("FAIL wrap_second: got %b want 0001", bus.grant);
    end
    bus.req = 4'b0000;
    step();
    step();
    n_cmp++;
    if (bus.done !== 4'b0001 || bus.result !== 1'b1) begin
      n_err++; $display("FAIL wrap_done0: got d=%b r=%b want 0001/1", bus.done, bus.result);
    end
    step();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    RESET_SIM  = 1'b1;
    SETUP_MODE = 1'b0;
    bus.req    = '0;
    bus.req_x  = '0;
    bus.req_y  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_setup_priority();
    test_reset_mid();
    test_withdraw_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
